final_project_hit_scorer: RTL and testbench

Scores player key presses against the three falling-note lanes. It sits directly downstream of the note-motion/display logic. It takes the three note Y positions and the raw push-buttons, then debounces and edge-detects each lane key. Each press is judged against a hit window around the strike line, and the running score is kept as 3-digit BCD. The block drives three active-low seven-segment digits with that score.

---
 rtl/final_project_pkg.sv | 47 ++++
 rtl/final_project_key_debounce.sv | 56 +++++
 rtl/final_project_seg7_decoder.sv | 13 +
 rtl/final_project_hit_scorer.sv | 93 +++++++++
 tb/tb_final_project_hit_scorer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/final_project_pkg.sv
// Shared constants for the rhythm-game hit scorer: lane count, point values, score ceiling,
// active-low seven-segment patterns {g,f,e,d,c,b,a}, and a saturating 3-digit BCD adder.
package final_project_pkg;

    localparam int NUM_LANES = 3;
    localparam int PTS_HIT   = 1;
    localparam int PTS_PERF  = 2;

    localparam logic [11:0] SCORE_MAX_BCD = 12'h999;

    // Index n holds the pattern for digit n.
    localparam logic [9:0][6:0] SEG7_ENC = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    // Adds a small binary increment (0..9) to a 3-digit BCD value, clamping at 999.
    function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [3:0] inc);
        logic [4:0]  dsum;
        logic [3:0]  carry;
        logic [11:0] res;
        carry = inc;
        res   = '0;
        for (int k = 0; k < 3; k++) begin
            dsum = {1'b0, a[4*k +: 4]} + {1'b0, carry};
            if (dsum > 5'd9) begin
                dsum = dsum + 5'd6;
                carry = 4'd1;
            end else begin
                carry = 4'd0;
            end
            res[4*k +: 4] = dsum[3:0];
        end
        return (carry != 4'd0) ? SCORE_MAX_BCD : res;
    endfunction

endpackage

// File: rtl/final_project_key_debounce.sv
// Synchronizes and debounces one active-low push-button and emits a one-cycle press pulse.
// Press appears 2 + DEBOUNCE_CYCLES + 1 cycles after a clean edge; no backpressure.
module final_project_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          rel_seen_q;
    logic          pressed;

    assign pressed = ~sync2_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (pressed != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A key held through reset must be seen released once before it may fire.
    assign press_o = level_q & ~level_prev_q & rel_seen_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rel_seen_q   <= 1'b0;
        end else begin
            sync1_q      <= key_n_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            if (sync2_q) rel_seen_q <= 1'b1;
        end
    end

endmodule

// File: rtl/final_project_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment {g,f,e,d,c,b,a}; codes above 9 blank.
module final_project_seg7_decoder
    import final_project_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG7_BLANK;
        if (bcd_i <= 4'd9) seg_o = SEG7_ENC[bcd_i];
    end

endmodule

// File: rtl/final_project_hit_scorer.sv
// Judges debounced lane presses against the hit window and keeps a saturating BCD score.
// hit/perfect/score register on the edge that samples press; displays follow the score combinationally.
module final_project_hit_scorer
    import final_project_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIT_LO          = 380,
    parameter int HIT_HI          = 430,
    parameter int PERF_LO         = 400,
    parameter int PERF_HI         = 416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic [9:0] y1,
    input  logic [9:0] y2,
    input  logic [9:0] y3,
    output logic [2:0] hit,
    output logic [2:0] perfect,
    output logic [6:0] seg7_dig0,
    output logic [6:0] seg7_dig1,
    output logic [6:0] seg7_dig2
);
    logic [NUM_LANES-1:0] press;
    logic [9:0]           y_w [NUM_LANES];
    logic                 unused_key3;

    logic [NUM_LANES-1:0] armed_q, armed_d;
    logic [NUM_LANES-1:0] hit_q, hit_d;
    logic [NUM_LANES-1:0] perf_q, perf_d;
    logic [11:0]          score_q, score_d;
    logic [3:0]           pts;

    assign y_w[0]      = y1;
    assign y_w[1]      = y2;
    assign y_w[2]      = y3;
    assign unused_key3 = key[3];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        final_project_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_i  (rst),
            .key_n_i(key[i]),
            .press_o(press[i])
        );
    end

    always_comb begin
        hit_d   = '0;
        perf_d  = '0;
        armed_d = armed_q;
        pts     = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(y_w[i]) < HIT_LO) begin
                armed_d[i] = 1'b1;
            end else if (press[i] && armed_q[i] && int'(y_w[i]) <= HIT_HI) begin
                hit_d[i]   = 1'b1;
                armed_d[i] = 1'b0;
                if (int'(y_w[i]) >= PERF_LO && int'(y_w[i]) <= PERF_HI) begin
                    perf_d[i] = 1'b1;
                    pts       = pts + 4'(PTS_PERF);
                end else begin
                    pts = pts + 4'(PTS_HIT);
                end
            end
        end
        score_d = bcd_add_sat(score_q, pts);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= '1;
            hit_q   <= '0;
            perf_q  <= '0;
            score_q <= '0;
        end else begin
            armed_q <= armed_d;
            hit_q   <= hit_d;
            perf_q  <= perf_d;
            score_q <= score_d;
        end
    end

    assign hit     = hit_q;
    assign perfect = perf_q;

    final_project_seg7_decoder u_dig0 (.bcd_i(score_q[3:0]),  .seg_o(seg7_dig0));
    final_project_seg7_decoder u_dig1 (.bcd_i(score_q[7:4]),  .seg_o(seg7_dig1));
    final_project_seg7_decoder u_dig2 (.bcd_i(score_q[11:8]), .seg_o(seg7_dig2));

endmodule

// File: tb/tb_final_project_hit_scorer.sv
// Directed bench for the hit scorer with a short debounce; checks pulses and the displayed score.
module tb_final_project_hit_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [9:0] y1 = 10'd0, y2 = 10'd0, y3 = 10'd0;
    logic [2:0] hit, perfect;
    logic [6:0] seg7_dig0, seg7_dig1, seg7_dig2;

    int n_tests = 0;
    int n_fail  = 0;
    int hit_cnt  [3];
    int perf_cnt [3];
    logic [2:0] last_hit, last_perf;

    final_project_hit_scorer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .hit      (hit),
        .perfect  (perfect),
        .seg7_dig0(seg7_dig0),
        .seg7_dig1(seg7_dig1),
        .seg7_dig2(seg7_dig2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (hit[i])     hit_cnt[i]++;
            if (perfect[i]) perf_cnt[i]++;
        end
        if (hit != 3'b000) begin
            last_hit  = hit;
            last_perf = perfect;
        end
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] disp_of(input int s);
        return {seg_of(s / 100), seg_of((s / 10) % 10), seg_of(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 3; i++) begin
            hit_cnt[i]  = 0;
            perf_cnt[i] = 0;
        end
        last_hit  = 3'b000;
        last_perf = 3'b000;
    endtask

    task automatic check_disp(input string tag, input int s);
        check(tag, {11'b0, seg7_dig2, seg7_dig1, seg7_dig0}, {11'b0, disp_of(s)});
    endtask

    task automatic press_keys(input logic [3:0] mask);
        key = ~mask;
        tick(10);
        key = 4'hF;
        tick(8);
    endtask

    // Re-arm the selected lanes, park their notes at the given Y, then press them together.
    task automatic round(input logic [2:0] mask, input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] c);
        if (mask[0]) y1 = 10'd50;
        if (mask[1]) y2 = 10'd50;
        if (mask[2]) y3 = 10'd50;
        tick(1);
        if (mask[0]) y1 = a;
        if (mask[1]) y2 = b;
        if (mask[2]) y3 = c;
        tick(1);
        press_keys({1'b0, mask});
    endtask

    initial begin
        clr_cnt();
        tick(2);
        check_disp("reset_disp", 0);
        check("reset_hit", {29'b0, hit}, 32'd0);
        check("reset_perf", {29'b0, perfect}, 32'd0);
        rst = 1'b0;
        tick(4);

        // Normal hit on lane 1, perfect on lane 2.
        clr_cnt();
        y1 = 10'd390;
        tick(1);
        press_keys(4'b0001);
        check("normal_hit_cnt", hit_cnt[0], 1);
        check("normal_perf_cnt", perf_cnt[0], 0);
        check_disp("normal_disp", 1);
        clr_cnt();
        y2 = 10'd408;
        tick(1);
        press_keys(4'b0010);
        check("perf_hit_cnt", hit_cnt[1], 1);
        check("perf_perf_cnt", perf_cnt[1], 1);
        check_disp("perf_disp", 3);

        // Bouncy press after re-arming lane 1.
        clr_cnt();
        y1 = 10'd50;
        tick(1);
        y1 = 10'd390;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            key[0] = ~key[0];
            tick(2);
        end
        key[0] = 1'b0;
        tick(10);
        key[0] = 1'b1;
        tick(8);
        check("bounce_hit_cnt", hit_cnt[0], 1);
        check_disp("bounce_disp", 4);
        clr_cnt();
        press_keys(4'b0001);
        check("disarmed_hit_cnt", hit_cnt[0], 0);
        check_disp("disarmed_disp", 4);
        round(3'b001, 10'd390, y2, y3);
        check("rearm_hit_cnt", hit_cnt[0], 1);
        check_disp("rearm_disp", 5);

        // Presses outside the window and on the unused key.
        clr_cnt();
        y3 = 10'd200;
        tick(1);
        press_keys(4'b0100);
        y3 = 10'd431;
        tick(1);
        press_keys(4'b0100);
        press_keys(4'b1000);
        check("outside_hits", hit_cnt[0] + hit_cnt[1] + hit_cnt[2], 0);
        check_disp("outside_disp", 5);

        // Climb to 098, then a simultaneous triple press carrying into hundreds.
        for (int k = 0; k < 15; k++) round(3'b111, 10'd408, 10'd408, 10'd408);
        round(3'b001, 10'd408, y2, y3);
        round(3'b001, 10'd390, y2, y3);
        check_disp("pre_098_disp", 98);
        clr_cnt();
        round(3'b111, 10'd410, 10'd410, 10'd385);
        check("simul_hit_vec", {29'b0, last_hit}, 32'd7);
        check("simul_perf_vec", {29'b0, last_perf}, 32'd3);
        check("simul_hit_total", hit_cnt[0] + hit_cnt[1] + hit_cnt[2], 3);
        check_disp("simul_disp", 103);

        // Saturation.
        for (int k = 0; k < 149; k++) round(3'b111, 10'd408, 10'd408, 10'd408);
        check_disp("pre_997_disp", 997);
        round(3'b111, 10'd408, 10'd408, 10'd408);
        check_disp("sat_disp", 999);
        round(3'b111, 10'd408, 10'd408, 10'd408);
        check_disp("sat_hold_disp", 999);

        // Reset mid-debounce with lane 1 held through the release of reset.
        y1 = 10'd390;
        key[0] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        check_disp("midrst_disp", 0);
        clr_cnt();
        rst = 1'b0;
        tick(15);
        check("held_no_hit", hit_cnt[0], 0);
        key[0] = 1'b1;
        tick(8);
        check("held_release_no_hit", hit_cnt[0], 0);
        check_disp("held_disp", 0);
        press_keys(4'b0001);
        check("post_rst_hit", hit_cnt[0], 1);
        check_disp("post_rst_disp", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
